moka_rv32i_dmem_resp: RTL and testbench

- Responder end of the core's data-memory bus (en / address / rd_data / wr_data / mem_we). The rv32i single-cycle core is the initiator.
- Provides word-addressed data RAM plus a small MMIO region:
  - character-out FIFO with valid/ready drain port
  - free-running timer with compare interrupt
  - sticky "tohost" completion register
- Sits beside the core in the SoC top and serves as the bench's memory model.

---
 rtl/moka_rv32i_dmem_resp.sv | 114 +++++++++++
 tb/tb_moka_rv32i_dmem_resp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/moka_rv32i_dmem_resp.sv
// Data-memory responder: word RAM plus MMIO char FIFO, timer and tohost; reads are zero-latency, writes commit at clk.
// Char FIFO drains on char_valid && char_ready; a push into a full FIFO without a same-cycle pop is dropped and flags overflow.
module moka_rv32i_dmem_resp #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        mem_we,
  output logic [31:0] rd_data,
  output logic        access_fault,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        timer_irq,
  output logic        done,
  output logic [31:0] done_code
);
  localparam int          AW        = $clog2(DEPTH);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  logic ram_sel, tx_sel, stat_sel, mtime_sel, cmp_sel, tohost_sel;
  logic mapped, acc_ok, wr_en;

  assign ram_sel      = {1'b0, address} < RAM_BYTES;
  assign tx_sel       = address == MMIO_BASE;
  assign stat_sel     = address == MMIO_BASE + 32'h04;
  assign mtime_sel    = address == MMIO_BASE + 32'h08;
  assign cmp_sel      = address == MMIO_BASE + 32'h0C;
  assign tohost_sel   = address == MMIO_BASE + 32'h10;
  assign mapped       = ram_sel | tx_sel | stat_sel | mtime_sel | cmp_sel | tohost_sel;
  assign access_fault = en && ((address[1:0] != 2'b00) || !mapped);
  assign acc_ok       = en && !access_fault;
  assign wr_en        = acc_ok && mem_we;

  // RAM is not reset; gating on rstn drops a write caught by reset at the edge.
  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] ram_idx;
  assign ram_idx = address[AW+1:2];

  always_ff @(posedge clk) begin
    if (wr_en && ram_sel && rstn) ram[ram_idx] <= wr_data;
  end

  logic [7:0] fifo [FIFO_DEPTH];
  logic [FW:0] wr_ptr, rd_ptr;
  logic empty, full, pop, push_req, push_ok, overflow;

  // Extra pointer bit distinguishes full from empty.
  assign empty      = wr_ptr == rd_ptr;
  assign full       = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
  assign char_valid = !empty;
  assign char_data  = fifo[rd_ptr[FW-1:0]];
  assign pop        = char_valid && char_ready;
  assign push_req   = wr_en && tx_sel;
  assign push_ok    = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok && rstn) fifo[wr_ptr[FW-1:0]] <= wr_data[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (FW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (FW+1)'(1);
      if (push_req && !push_ok)                  overflow <= 1'b1;
      else if (wr_en && stat_sel && wr_data[2])  overflow <= 1'b0;
    end
  end

  logic [31:0] mtime, mtimecmp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= mtime >= mtimecmp;
      mtime     <= (wr_en && mtime_sel) ? wr_data : mtime + 32'd1;
      if (wr_en && cmp_sel) mtimecmp <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done      <= 1'b0;
      done_code <= '0;
    end else if (wr_en && tohost_sel && !done) begin
      done      <= 1'b1;
      done_code <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (acc_ok) begin
      if (ram_sel)         rd_data = ram[ram_idx];
      else if (stat_sel)   rd_data = {29'd0, overflow, full, empty};
      else if (mtime_sel)  rd_data = mtime;
      else if (cmp_sel)    rd_data = mtimecmp;
      else if (tohost_sel) rd_data = done_code;
    end
  end
endmodule

// File: tb/tb_moka_rv32i_dmem_resp.sv
// Bench for moka_rv32i_dmem_resp: directed steps then random accesses, every cycle compared to a queue/array reference model.
module tb_moka_rv32i_dmem_resp;
  localparam int          DEPTH = 1024;
  localparam int          FD    = 8;
  localparam logic [31:0] MB    = 32'h1000_0000;

  logic        clk, rstn, en, mem_we, char_ready;
  logic [31:0] address, wr_data, rd_data, done_code;
  logic        access_fault, char_valid, timer_irq, done;
  logic [7:0]  char_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [7:0]  q [$];
  bit          m_ovf, m_irq, m_done;
  logic [31:0] m_time, m_cmp, m_code;

  logic [31:0] last_rd;
  logic [7:0]  last_char;
  bit          last_fault, last_valid, last_irq;

  moka_rv32i_dmem_resp #(.DEPTH(DEPTH), .MMIO_BASE(MB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .en(en), .address(address), .wr_data(wr_data),
    .mem_we(mem_we), .rd_data(rd_data), .access_fault(access_fault),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .timer_irq(timer_irq), .done(done), .done_code(done_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a);
    logic [31:0] off;
    off = a - MB;
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < DEPTH * 4) return 1'b0;
    if (a >= MB && off <= 32'd16) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
    m_done = 1'b0;
    m_time = 32'd0;
    m_cmp  = 32'hFFFF_FFFF;
    m_code = 32'd0;
  endtask

  // One bus cycle: drive just after posedge, compare at negedge, advance model past the next posedge.
  task automatic step(input bit e, input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
    logic [31:0] exp_rd, off;
    bit known, f, pop, was_full, wr;
    en = e; mem_we = we; address = a; wr_data = d; char_ready = rdy;
    @(negedge clk);
    f = e && is_fault(a);
    off = a - MB;
    known = 1'b1;
    exp_rd = 32'd0;
    if (e && !f) begin
      if (a < DEPTH * 4) begin
        if (m_ram.exists(int'(a >> 2))) exp_rd = m_ram[int'(a >> 2)];
        else known = 1'b0;
      end else begin
        case (off)
          32'd4:   exp_rd = {29'd0, m_ovf, q.size() == FD, q.size() == 0};
          32'd8:   exp_rd = m_time;
          32'd12:  exp_rd = m_cmp;
          32'd16:  exp_rd = m_code;
          default: exp_rd = 32'd0;
        endcase
      end
    end
    check("access_fault", 32'(access_fault), 32'(f));
    if (known) check("rd_data", rd_data, exp_rd);
    check("char_valid", 32'(char_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("char_data", 32'(char_data), 32'(q[0]));
    check("timer_irq", 32'(timer_irq), 32'(m_irq));
    check("done", 32'(done), 32'(m_done));
    check("done_code", done_code, m_code);
    last_rd = rd_data; last_fault = access_fault; last_valid = char_valid;
    last_char = char_data; last_irq = timer_irq;
    @(posedge clk);
    #1;
    pop      = (q.size() != 0) && rdy;
    was_full = q.size() == FD;
    wr       = e && we && !f;
    m_irq    = m_time >= m_cmp;
    if (pop) void'(q.pop_front());
    if (wr && a < DEPTH * 4) m_ram[int'(a >> 2)] = d;
    if (wr && off == 32'd0) begin
      if (!was_full || pop) q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
    if (wr && off == 32'd4 && d[2]) m_ovf = 1'b0;
    if (wr && off == 32'd12) m_cmp = d;
    if (wr && off == 32'd16 && !m_done) begin
      m_done = 1'b1;
      m_code = d;
    end
    m_time = (wr && off == 32'd8) ? d : m_time + 32'd1;
  endtask

  initial begin
    logic [31:0] a, d;
    int sel;
    en = 0; mem_we = 0; address = 0; wr_data = 0; char_ready = 0; rstn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_irq", 32'(timer_irq), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_code", done_code, 32'd0);
    rstn = 1;

    // RAM store/load
    step(1, 1, 32'h40, 32'h1111_1111, 0);
    step(1, 1, 32'h40, 32'hDEAD_BEEF, 0);
    check("ram_same_cycle_old", last_rd, 32'h1111_1111);
    step(1, 0, 32'h40, 32'd0, 0);
    check("ram_load", last_rd, 32'hDEAD_BEEF);
    check("ram_load_fault", 32'(last_fault), 32'd0);

    // Faults
    step(1, 1, 32'h0, 32'h1234_5678, 0);
    step(1, 0, 32'h42, 32'd0, 0);
    check("misaligned_fault", 32'(last_fault), 32'd1);
    check("misaligned_rd", last_rd, 32'd0);
    step(1, 1, 32'h2000_0000, 32'hBAD0_BAD0, 0);
    check("unmapped_fault", 32'(last_fault), 32'd1);
    step(1, 0, 32'h0, 32'd0, 0);
    check("unmapped_no_write", last_rd, 32'h1234_5678);
    step(0, 0, 32'h42, 32'd0, 0);
    check("idle_fault", 32'(last_fault), 32'd0);
    check("idle_rd", last_rd, 32'd0);

    // FIFO fill, overflow, drain
    for (int i = 0; i < 8; i++) step(1, 1, MB, 32'h41 + i, 0);
    step(1, 0, MB + 4, 32'd0, 0);
    check("stat_full", last_rd, 32'b010);
    step(1, 1, MB, 32'h49, 0);
    step(1, 0, MB + 4, 32'd0, 0);
    check("stat_overflow", last_rd, 32'b110);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 32'd0, 32'd0, 1);
      check("drain_valid", 32'(last_valid), 32'd1);
      check("drain_order", 32'(last_char), 32'h41 + i);
    end
    step(1, 0, MB + 4, 32'd0, 1);
    check("stat_drained", last_rd, 32'b101);
    step(1, 1, MB + 4, 32'h4, 1);
    step(1, 0, MB + 4, 32'd0, 0);
    check("stat_ovf_clear", last_rd, 32'b001);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1, 1, MB, 32'h30 + i, 0);
    step(1, 1, MB, 32'h5A, 1);
    check("full_pushpop_head", 32'(last_char), 32'h30);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 32'd0, 32'd0, 1);
      check("pushpop_order", 32'(last_char), (i < 7) ? 32'h31 + i : 32'h5A);
    end
    step(1, 0, MB + 4, 32'd0, 0);
    check("pushpop_no_ovf", last_rd, 32'b001);

    // Timer compare
    step(1, 1, MB + 8, 32'd0, 0);
    step(1, 1, MB + 12, 32'd20, 0);
    step(1, 1, MB + 8, 32'd10, 0);
    repeat (10) step(0, 0, 32'd0, 32'd0, 0);
    step(0, 0, 32'd0, 32'd0, 0);
    check("irq_before_11", 32'(last_irq), 32'd0);
    step(0, 0, 32'd0, 32'd0, 0);
    check("irq_at_11", 32'(last_irq), 32'd1);
    step(1, 1, MB + 8, 32'hFFFF_FFFF, 0);
    step(1, 0, MB + 8, 32'd0, 0);
    step(1, 0, MB + 8, 32'd0, 0);
    check("mtime_wrap", last_rd, 32'd0);
    step(1, 1, MB + 8, 32'd100, 0);
    step(0, 0, 32'd0, 32'd0, 0);
    step(1, 1, MB + 12, 32'hFFFF_FFFF, 0);
    check("irq_high", 32'(last_irq), 32'd1);
    step(0, 0, 32'd0, 32'd0, 0);
    check("irq_fall_hold", 32'(last_irq), 32'd1);
    step(0, 0, 32'd0, 32'd0, 0);
    check("irq_fall", 32'(last_irq), 32'd0);

    // TOHOST sticky
    step(1, 1, MB + 16, 32'd1, 0);
    step(1, 1, MB + 16, 32'd5, 0);
    step(1, 0, MB + 16, 32'd0, 0);
    check("tohost_read", last_rd, 32'd1);
    check("done_set", 32'(done), 32'd1);
    check("done_code_first", done_code, 32'd1);

    // Asynchronous reset during a drain
    for (int i = 0; i < 4; i++) step(1, 1, MB, 32'h61 + i, 0);
    step(0, 0, 32'd0, 32'd0, 1);
    en = 1; mem_we = 0; address = MB + 8; char_ready = 1;
    @(negedge clk);
    #1;
    rstn = 0;
    #1;
    check("arst_char_valid", 32'(char_valid), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_done_code", done_code, 32'd0);
    check("arst_mtime", rd_data, 32'd0);
    check("arst_irq", 32'(timer_irq), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1;
    model_reset();
    step(1, 0, MB + 8, 32'd0, 0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 11);
      d = $urandom;
      case (sel)
        0, 1, 2, 3: a = ($urandom_range(0, 8) == 8) ? 32'((DEPTH - 1) * 4) : 32'($urandom_range(0, 7) * 4);
        4:  a = MB;
        5:  a = MB + 4;
        6:  a = MB + 8;
        7:  a = MB + 12;
        8:  a = MB + 16;
        9:  a = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
        10: begin
          case ($urandom_range(0, 3))
            0:       a = 32'(DEPTH * 4);
            1:       a = MB + 20;
            2:       a = 32'h2000_0000;
            default: a = 32'hFFFF_FFFC;
          endcase
        end
        default: a = MB + 2;
      endcase
      if (sel == 4) d = {24'd0, d[7:0]};
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, a, d, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
